// File: rtl/mem_arbiter.sv
// Two-requester (CPU / DMA) arbiter for a single-port byte memory.
// Round-robin grant, fixed WAIT-state access, one-cycle ack per transaction.
module mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int WAIT   = 1
) (
  input  logic              ph1,
  input  logic              reset,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_ack,

  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [7:0]        dma_wdata,
  output logic [7:0]        dma_rdata,
  output logic              dma_ack,

  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              mem_read,
  output logic              mem_write,

  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT);

  state_t     state;
  state_t     state_next;
  logic [3:0] wait_cnt;
  logic       lat_we;
  logic       any_req;
  logic       grant_dma;
  logic       last_cycle;

  // DMA wins only when alone or when the CPU was the most recent grantee.
  assign any_req    = cpu_req | dma_req;
  assign grant_dma  = dma_req & (~cpu_req | ~owner);
  assign last_cycle = (wait_cnt == 4'd0);

  always_ff @(posedge ph1) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    cpu_ack    = 1'b0;
    dma_ack    = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        busy      = 1'b1;
        mem_read  = ~lat_we;
        mem_write = lat_we & last_cycle;
        if (last_cycle) begin
          state_next = ACK;
        end
      end
      ACK: begin
        busy       = 1'b1;
        cpu_ack    = ~owner;
        dma_ack    = owner;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The memory address/data registers double as the latched request, so they
  // naturally hold their value through ACK and the following IDLE.
  always_ff @(posedge ph1) begin
    if (reset) begin
      wait_cnt  <= 4'd0;
      lat_we    <= 1'b0;
      owner     <= 1'b1;
      mem_addr  <= '0;
      mem_wdata <= 8'h00;
      cpu_rdata <= 8'h00;
      dma_rdata <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner     <= grant_dma;
            wait_cnt  <= WAIT_LOAD;
            lat_we    <= grant_dma ? dma_we    : cpu_we;
            mem_addr  <= grant_dma ? dma_addr  : cpu_addr;
            mem_wdata <= grant_dma ? dma_wdata : cpu_wdata;
          end
        end
        ACCESS: begin
          if (last_cycle) begin
            if (!lat_we) begin
              if (owner) begin
                dma_rdata <= mem_rdata;
              end else begin
                cpu_rdata <= mem_rdata;
              end
            end
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with WAIT=1, one with WAIT=0.
// Memory read data is a fixed function of the address (addr ^ 0xB5).
module tb_mem_arbiter;

  logic       ph1 = 1'b0;
  logic       reset;

  logic       cpu_req, cpu_we, cpu_ack;
  logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic       dma_req, dma_we, dma_ack;
  logic [7:0] dma_addr, dma_wdata, dma_rdata;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_read, mem_write, busy, owner;

  logic       w0_cpu_req, w0_cpu_we, w0_cpu_ack;
  logic [7:0] w0_cpu_addr, w0_cpu_wdata, w0_cpu_rdata;
  logic       w0_dma_ack;
  logic [7:0] w0_dma_rdata;
  logic [7:0] w0_mem_addr, w0_mem_wdata, w0_mem_rdata;
  logic       w0_mem_read, w0_mem_write, w0_busy, w0_owner;

  int assert_count = 0;
  int fail_count   = 0;
  int write_count  = 0;

  always #5 ph1 = ~ph1;

  assign mem_rdata    = mem_addr ^ 8'hB5;
  assign w0_mem_rdata = 8'hC3;

  always @(posedge ph1) begin
    if (mem_write) write_count <= write_count + 1;
  end

  mem_arbiter #(.ADDR_W(8), .WAIT(1)) dut (
    .ph1(ph1), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .busy(busy), .owner(owner)
  );

  mem_arbiter #(.ADDR_W(8), .WAIT(0)) dut_w0 (
    .ph1(ph1), .reset(reset),
    .cpu_req(w0_cpu_req), .cpu_we(w0_cpu_we), .cpu_addr(w0_cpu_addr), .cpu_wdata(w0_cpu_wdata),
    .cpu_rdata(w0_cpu_rdata), .cpu_ack(w0_cpu_ack),
    .dma_req(1'b0), .dma_we(1'b0), .dma_addr(8'h00), .dma_wdata(8'h00),
    .dma_rdata(w0_dma_rdata), .dma_ack(w0_dma_ack),
    .mem_addr(w0_mem_addr), .mem_wdata(w0_mem_wdata), .mem_rdata(w0_mem_rdata),
    .mem_read(w0_mem_read), .mem_write(w0_mem_write), .busy(w0_busy), .owner(w0_owner)
  );

  task automatic tick();
    @(posedge ph1);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic creq, input logic cwe, input logic [7:0] caddr,
                               input logic [7:0] cdata, input logic dreq, input logic dwe,
                               input logic [7:0] daddr, input logic [7:0] ddata);
    cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cdata;
    dma_req = dreq; dma_we = dwe; dma_addr = daddr; dma_wdata = ddata;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  n;
    int  wc;
    logic seen;

    reset = 1'b1;
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    w0_cpu_req = 0; w0_cpu_we = 0; w0_cpu_addr = 8'h00; w0_cpu_wdata = 8'h00;
    tick(); tick();
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_owner", owner, 1);
    checkOutput("rst_mem_addr", mem_addr, 8'h00);
    checkOutput("rst_cpu_rdata", cpu_rdata, 8'h00);
    checkOutput("rst_strobes", {mem_read, mem_write, cpu_ack, dma_ack}, 4'b0000);
    reset = 1'b0;
    tick();

    $display("[TB] Scenario 1: CPU read");
    applyStimulus(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
    tick();
    checkOutput("s1_acc1_read", mem_read, 1);
    checkOutput("s1_acc1_addr", mem_addr, 8'h10);
    checkOutput("s1_acc1_busy_owner", {busy, owner}, 2'b10);
    checkOutput("s1_acc1_ack", cpu_ack, 0);
    tick();
    checkOutput("s1_acc2_read", mem_read, 1);
    checkOutput("s1_acc2_ack", cpu_ack, 0);
    tick();
    checkOutput("s1_ack", cpu_ack, 1);
    checkOutput("s1_dma_ack", dma_ack, 0);
    checkOutput("s1_rdata", cpu_rdata, 8'hA5);
    checkOutput("s1_ack_read", mem_read, 0);
    applyStimulus(0, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
    tick();
    checkOutput("s1_idle_ack", cpu_ack, 0);
    checkOutput("s1_idle_busy", busy, 0);
    checkOutput("s1_rdata_hold", cpu_rdata, 8'hA5);

    $display("[TB] Scenario 2: DMA write, req dropped mid-access");
    wc = write_count;
    applyStimulus(0, 0, 8'h00, 8'h00, 1, 1, 8'h20, 8'h3C);
    tick();
    checkOutput("s2_acc1_write", {mem_read, mem_write}, 2'b00);
    checkOutput("s2_acc1_owner", owner, 1);
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h99, 8'h99);
    tick();
    checkOutput("s2_acc2_write", mem_write, 1);
    checkOutput("s2_acc2_addr", mem_addr, 8'h20);
    checkOutput("s2_acc2_wdata", mem_wdata, 8'h3C);
    tick();
    checkOutput("s2_ack", dma_ack, 1);
    checkOutput("s2_ack_cpu", cpu_ack, 0);
    checkOutput("s2_ack_write", mem_write, 0);
    checkOutput("s2_cpu_rdata_kept", cpu_rdata, 8'hA5);
    tick();
    checkOutput("s2_write_count", write_count - wc, 1);
    checkOutput("s2_idle_wdata", mem_wdata, 8'h3C);

    $display("[TB] Scenario 3: round-robin");
    reset = 1'b1;
    applyStimulus(1, 0, 8'h30, 8'h00, 1, 0, 8'h31, 8'h00);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      do begin
        tick();
        n++;
      end while (!(cpu_ack || dma_ack) && n < 10);
      seen = cpu_ack | dma_ack;
      checkOutput($sformatf("s3_ack_seen_%0d", i), seen, 1);
      checkOutput($sformatf("s3_spacing_%0d", i), n, (i == 0) ? 3 : 4);
      checkOutput($sformatf("s3_owner_%0d", i), owner, i % 2);
      checkOutput($sformatf("s3_acks_%0d", i), {cpu_ack, dma_ack}, (i % 2) ? 2'b01 : 2'b10);
      if (i % 2) checkOutput($sformatf("s3_rdata_%0d", i), dma_rdata, 8'h84);
      else       checkOutput($sformatf("s3_rdata_%0d", i), cpu_rdata, 8'h85);
    end
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    tick();
    checkOutput("s3_idle_busy", busy, 0);

    $display("[TB] Scenario 4: address change after grant");
    applyStimulus(1, 0, 8'h40, 8'h00, 0, 0, 8'h00, 8'h00);
    tick();
    applyStimulus(1, 1, 8'hFF, 8'h99, 0, 0, 8'h00, 8'h00);
    checkOutput("s4_acc1_addr", mem_addr, 8'h40);
    tick();
    checkOutput("s4_acc2_addr", mem_addr, 8'h40);
    checkOutput("s4_acc2_strobes", {mem_read, mem_write}, 2'b10);
    tick();
    checkOutput("s4_ack", cpu_ack, 1);
    checkOutput("s4_ack_addr", mem_addr, 8'h40);
    checkOutput("s4_rdata", cpu_rdata, 8'hF5);
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    tick();
    checkOutput("s4_idle_addr", mem_addr, 8'h40);

    $display("[TB] Scenario 5: reset during DMA write");
    wc = write_count;
    applyStimulus(0, 0, 8'h00, 8'h00, 1, 1, 8'h50, 8'h77);
    tick();
    checkOutput("s5_acc1_busy", busy, 1);
    reset = 1'b1;
    tick();
    checkOutput("s5_rst_strobes", {mem_read, mem_write, cpu_ack, dma_ack, busy}, 5'b00000);
    checkOutput("s5_rst_owner", owner, 1);
    checkOutput("s5_rst_mem", {mem_addr, mem_wdata}, 16'h0000);
    checkOutput("s5_rst_rdata", {cpu_rdata, dma_rdata}, 16'h0000);
    reset = 1'b0;
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    tick();
    checkOutput("s5_no_ack", dma_ack, 0);
    tick();
    checkOutput("s5_no_write", write_count - wc, 0);

    $display("[TB] Scenario 6: WAIT=0");
    w0_cpu_req = 1; w0_cpu_we = 1; w0_cpu_addr = 8'h60; w0_cpu_wdata = 8'h42;
    tick();
    checkOutput("s6_acc_write", w0_mem_write, 1);
    checkOutput("s6_acc_addr", {w0_mem_addr, w0_mem_wdata}, 16'h6042);
    checkOutput("s6_acc_ack", w0_cpu_ack, 0);
    w0_cpu_req = 0;
    tick();
    checkOutput("s6_ack", w0_cpu_ack, 1);
    checkOutput("s6_ack_write", w0_mem_write, 0);
    tick();
    checkOutput("s6_idle_ack", {w0_cpu_ack, w0_busy}, 2'b00);
    w0_cpu_req = 1; w0_cpu_we = 0; w0_cpu_addr = 8'h61;
    tick();
    checkOutput("s6_rd_read", w0_mem_read, 1);
    tick();
    checkOutput("s6_rd_ack", w0_cpu_ack, 1);
    checkOutput("s6_rd_rdata", w0_cpu_rdata, 8'hC3);
    checkOutput("s6_dma_side", {w0_dma_ack, w0_dma_rdata}, 9'h000);
    w0_cpu_req = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
